// File: rtl/load_store_unit_if.sv
// Request, data-memory and writeback signals of the load/store unit.
// slave is the unit's own view; master is the execute stage plus data memory.
interface load_store_unit_if;
    // execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        is_store;
    logic [4:0]  rd;
    // data memory bus
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    // writeback response
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_misaligned;
    logic        resp_buserr;

    modport slave (
        input  req_valid, addr, wdata, funct3, is_store, rd, mem_ready, mem_rdata,
        output req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
               resp_valid, resp_data, resp_rd, resp_misaligned, resp_buserr
    );

    modport master (
        output req_valid, addr, wdata, funct3, is_store, rd, mem_ready, mem_rdata,
        input  req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
               resp_valid, resp_data, resp_rd, resp_misaligned, resp_buserr
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, alignment check,
// byte-lane steering, load extension and a memory timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [1:0]         addr_lo, addr_lo_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [4:0]         rd_q, rd_d;

    logic               mem_valid_d;
    logic               mem_we_d;
    logic [3:0]         mem_wstrb_d;
    logic [31:0]        mem_addr_d;
    logic [31:0]        mem_wdata_d;
    logic               resp_valid_d;
    logic [31:0]        resp_data_d;
    logic [4:0]         resp_rd_d;
    logic               resp_misaligned_d;
    logic               resp_buserr_d;

    logic               fault_c;
    logic [3:0]         strb_c;
    logic [31:0]        wdata_c;
    logic [31:0]        lane_c;
    logic [31:0]        load_data_c;

    assign bus.req_ready = (state == IDLE) && !reset;

    // Illegal width encodings and misaligned addresses fault without a bus access
    always_comb begin
        fault_c = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: fault_c = 1'b0;
            3'b001, 3'b101: fault_c = bus.addr[0];
            3'b010:         fault_c = (bus.addr[1:0] != 2'b00);
            default:        fault_c = 1'b1;
        endcase
        if (bus.is_store && bus.funct3[2]) begin
            fault_c = 1'b1;
        end
    end

    // Store byte-enable and data replication across lanes
    always_comb begin
        strb_c  = 4'b0000;
        wdata_c = 32'h0;
        if (bus.is_store) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    strb_c  = 4'b0001 << bus.addr[1:0];
                    wdata_c = {4{bus.wdata[7:0]}};
                end
                2'b01: begin
                    strb_c  = bus.addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{bus.wdata[15:0]}};
                end
                default: begin
                    strb_c  = 4'b1111;
                    wdata_c = bus.wdata;
                end
            endcase
        end
    end

    // Shift the addressed lane down to bit 0 and sign/zero extend it
    always_comb begin
        lane_c = bus.mem_rdata >> {addr_lo, 3'b000};
        case (funct3_q)
            3'b000:  load_data_c = {{24{lane_c[7]}},  lane_c[7:0]};
            3'b001:  load_data_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  load_data_c = {24'h0, lane_c[7:0]};
            3'b101:  load_data_c = {16'h0, lane_c[15:0]};
            default: load_data_c = bus.mem_rdata;
        endcase
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_d           = state;
        cnt_d             = cnt;
        addr_lo_d         = addr_lo;
        funct3_d          = funct3_q;
        rd_d              = rd_q;
        mem_valid_d       = bus.mem_valid;
        mem_we_d          = bus.mem_we;
        mem_wstrb_d       = bus.mem_wstrb;
        mem_addr_d        = bus.mem_addr;
        mem_wdata_d       = bus.mem_wdata;
        resp_valid_d      = 1'b0;
        resp_data_d       = 32'h0;
        resp_rd_d         = 5'd0;
        resp_misaligned_d = 1'b0;
        resp_buserr_d     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    rd_d      = bus.rd;
                    funct3_d  = bus.funct3;
                    addr_lo_d = bus.addr[1:0];
                    cnt_d     = '0;
                    if (fault_c) begin
                        state_d           = RESP;
                        resp_valid_d      = 1'b1;
                        resp_misaligned_d = 1'b1;
                        resp_rd_d         = bus.rd;
                    end else begin
                        state_d     = MEM;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.addr[31:2], 2'b00};
                        mem_we_d    = bus.is_store;
                        mem_wstrb_d = strb_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            MEM: begin
                // a ready on the final allowed cycle still completes normally
                if (bus.mem_ready) begin
                    state_d      = RESP;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_data_d  = bus.mem_we ? 32'h0 : load_data_c;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    mem_valid_d   = 1'b0;
                    resp_valid_d  = 1'b1;
                    resp_rd_d     = rd_q;
                    resp_buserr_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request capture and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            addr_lo             <= 2'b00;
            funct3_q            <= 3'b000;
            rd_q                <= 5'd0;
            bus.mem_valid       <= 1'b0;
            bus.mem_we          <= 1'b0;
            bus.mem_wstrb       <= 4'b0000;
            bus.mem_addr        <= 32'h0;
            bus.mem_wdata       <= 32'h0;
            bus.resp_valid      <= 1'b0;
            bus.resp_data       <= 32'h0;
            bus.resp_rd         <= 5'd0;
            bus.resp_misaligned <= 1'b0;
            bus.resp_buserr     <= 1'b0;
        end else begin
            state               <= state_d;
            cnt                 <= cnt_d;
            addr_lo             <= addr_lo_d;
            funct3_q            <= funct3_d;
            rd_q                <= rd_d;
            bus.mem_valid       <= mem_valid_d;
            bus.mem_we          <= mem_we_d;
            bus.mem_wstrb       <= mem_wstrb_d;
            bus.mem_addr        <= mem_addr_d;
            bus.mem_wdata       <= mem_wdata_d;
            bus.resp_valid      <= resp_valid_d;
            bus.resp_data       <= resp_data_d;
            bus.resp_rd         <= resp_rd_d;
            bus.resp_misaligned <= resp_misaligned_d;
            bus.resp_buserr     <= resp_buserr_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// operations checked against an arithmetic reference model.
module tb_load_store_unit;
    localparam int unsigned TB_TIMEOUT = 16;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: access size from funct3[1:0] (0 byte, 1 half, 2 word)
    function automatic bit m_fault(input int f, input bit st, input longint a);
        int size;
        size = f % 4;
        if (f == 3 || f == 6 || f == 7) return 1'b1;
        if (st && f >= 4)               return 1'b1;
        if (size == 1 && (a % 2) != 0)  return 1'b1;
        if (size == 2 && (a % 4) != 0)  return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input int f, input longint a, input longint rdata);
        longint v;
        v = rdata / (longint'(1) << ((a % 4) * 8));
        case (f % 4)
            0: begin
                v = v % 256;
                if (f < 4 && v >= 128) v = v + 64'hFFFF_FF00;
            end
            1: begin
                v = v % 65536;
                if (f < 4 && v >= 32768) v = v + 64'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_strb(input int f, input bit st, input longint a);
        if (!st) return 4'd0;
        case (f % 4)
            0:       return 4'(1 << (a % 4));
            1:       return ((a % 4) >= 2) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input int f, input longint w);
        case (f % 4)
            0:       return 32'((w % 256) * 64'h0101_0101);
            1:       return 32'((w % 65536) * 64'h0001_0001);
            default: return 32'(w);
        endcase
    endfunction

    // Issue one request, serve memory with mem_ready in MEM cycle ready_at
    // (0 = never), and check the bus and the response.
    task automatic run_op(input logic [2:0] f3, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r, input logic [31:0] rdata,
                          input int ready_at, input logic exp_fault, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data, input string name);
        bit   done;
        bit   timed;
        int   k;
        logic [31:0] exp_addr;
        exp_addr = {a[31:2], 2'b00};
        bus.req_valid = 1'b1;
        bus.funct3    = f3;
        bus.is_store  = st;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.rd        = r;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s.accept: req_ready=%b required 1", name, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.addr      = $urandom;
        bus.wdata     = $urandom;
        bus.funct3    = 3'($urandom);
        bus.is_store  = 1'($urandom);
        bus.rd        = 5'($urandom);
        if (exp_fault) begin
            vectors++;
            if ({bus.mem_valid, bus.resp_valid, bus.resp_misaligned, bus.resp_buserr, bus.resp_rd, bus.resp_data}
                !== {1'b0, 1'b1, 1'b1, 1'b0, r, 32'h0}) begin
                miscompares++;
                $display("FAIL %s.fault_resp: got mv/rv/mis/err/rd/data=%b%b%b%b/%h/%h required 0111/%h/00000000",
                         name, bus.mem_valid, bus.resp_valid, bus.resp_misaligned, bus.resp_buserr,
                         bus.resp_rd, bus.resp_data, r);
            end
        end else begin
            done  = 1'b0;
            timed = 1'b0;
            k     = 1;
            while (!done) begin
                vectors++;
                if ({bus.mem_valid, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.resp_valid, bus.req_ready}
                    !== {1'b1, exp_addr, st, exp_strb, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL %s.mem_cycle%0d: got valid=%b addr=%h we=%b strb=%b rv=%b rdy=%b required 1 %h %b %b 0 0",
                             name, k, bus.mem_valid, bus.mem_addr, bus.mem_we, bus.mem_wstrb,
                             bus.resp_valid, bus.req_ready, exp_addr, st, exp_strb);
                end
                if (st) begin
                    vectors++;
                    if (bus.mem_wdata !== exp_wdata) begin
                        miscompares++;
                        $display("FAIL %s.mem_wdata: got %h required %h", name, bus.mem_wdata, exp_wdata);
                    end
                end
                if (k == ready_at) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rdata;
                    done = 1'b1;
                end else if (k == int'(TB_TIMEOUT)) begin
                    done  = 1'b1;
                    timed = 1'b1;
                end
                @(negedge clk);
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                k++;
            end
            vectors++;
            if ({bus.mem_valid, bus.resp_valid, bus.resp_misaligned, bus.resp_buserr, bus.resp_rd, bus.resp_data}
                !== {1'b0, 1'b1, 1'b0, timed, r, (timed ? 32'h0 : exp_data)}) begin
                miscompares++;
                $display("FAIL %s.resp: got mv/rv/mis/err/rd/data=%b%b%b%b/%h/%h required 010%b/%h/%h",
                         name, bus.mem_valid, bus.resp_valid, bus.resp_misaligned, bus.resp_buserr,
                         bus.resp_rd, bus.resp_data, timed, r, (timed ? 32'h0 : exp_data));
            end
        end
        @(negedge clk);
        vectors++;
        if ({bus.resp_valid, bus.resp_misaligned, bus.resp_buserr, bus.req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL %s.after: got rv/mis/err/rdy=%b%b%b%b required 0001",
                     name, bus.resp_valid, bus.resp_misaligned, bus.resp_buserr, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b010;
        bus.is_store  = 1'b0;
        bus.addr      = 32'h40;
        bus.wdata     = 32'h0;
        bus.rd        = 5'd1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset.req_ready: got %b required 0", bus.req_ready);
        end
        vectors++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.resp_valid,
             bus.resp_data, bus.resp_rd, bus.resp_misaligned, bus.resp_buserr} !== 113'h0) begin
            miscompares++;
            $display("FAIL reset.outputs: got mv=%b we=%b strb=%b addr=%h wd=%h rv=%b data=%h rd=%h mis=%b err=%b required all 0",
                     bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.resp_valid,
                     bus.resp_data, bus.resp_rd, bus.resp_misaligned, bus.resp_buserr);
        end
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset.release_ready: got %b required 1", bus.req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(3'b000, 1'b0, 32'h0000_1003, 32'h0, 5'd1, 32'h80FF_0000, 1, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80, "lb");
        run_op(3'b101, 1'b0, 32'h0000_2002, 32'h0, 5'd2, 32'hBEEF_1234, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_BEEF, "lhu");
        run_op(3'b001, 1'b0, 32'h0000_2002, 32'h0, 5'd3, 32'hBEEF_1234, 2, 1'b0, 4'b0000, 32'h0, 32'hFFFF_BEEF, "lh");
        run_op(3'b000, 1'b1, 32'h0000_0011, 32'h1234_56AB, 5'd4, 32'hFFFF_FFFF, 1, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0, "sb");
        run_op(3'b001, 1'b1, 32'h0000_0202, 32'hAAAA_5678, 5'd5, 32'h0, 3, 1'b0, 4'b1100, 32'h5678_5678, 32'h0, "sh");
        run_op(3'b010, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 5'd6, 32'h0, 1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0, "sw");
        run_op(3'b010, 1'b0, 32'h0000_0006, 32'h0, 5'd7, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0, "lw_misaligned");
        run_op(3'b011, 1'b0, 32'h0000_0008, 32'h0, 5'd8, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0, "funct3_011");
        run_op(3'b100, 1'b1, 32'h0000_0008, 32'h0, 5'd9, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0, "store_f3_100");
        run_op(3'b101, 1'b0, 32'h0000_0003, 32'h0, 5'd10, 32'h0, 1, 1'b1, 4'b0000, 32'h0, 32'h0, "lhu_odd");
    endtask

    task automatic test_timeout();
        run_op(3'b010, 1'b0, 32'h0000_3000, 32'h0, 5'd11, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, "timeout");
        run_op(3'b010, 1'b0, 32'h0000_3004, 32'h0, 5'd12, 32'h1234_5678, int'(TB_TIMEOUT), 1'b0, 4'b0000, 32'h0,
               32'h1234_5678, "ready_on_last");
        run_op(3'b010, 1'b1, 32'h0000_3008, 32'h0BAD_F00D, 5'd13, 32'h0, 0, 1'b0, 4'b1111, 32'h0BAD_F00D, 32'h0,
               "store_timeout");
    endtask

    task automatic test_reset_abort();
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b010;
        bus.is_store  = 1'b0;
        bus.addr      = 32'h0000_0100;
        bus.rd        = 5'd14;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort.mem_valid_wait3: got %b required 1", bus.mem_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.mem_valid, bus.resp_valid, bus.req_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort.in_reset: got mv/rv/rdy=%b%b%b required 000",
                     bus.mem_valid, bus.resp_valid, bus.req_ready);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort.ready_after: got %b required 1", bus.req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.mem_valid, bus.resp_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL abort.quiet%0d: got mv/rv=%b%b required 00", i, bus.mem_valid, bus.resp_valid);
            end
        end
        run_op(3'b100, 1'b0, 32'h0000_0102, 32'h0, 5'd15, 32'h00C3_0000, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_00C3,
               "lbu_after_abort");
    endtask

    task automatic test_back_to_back();
        int n_rdy;
        int n_resp;
        n_rdy  = 0;
        n_resp = 0;
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b010;
        bus.is_store  = 1'b0;
        bus.addr      = 32'h0000_0040;
        bus.rd        = 5'd3;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 30; i++) begin
            if (bus.req_ready === 1'b1) n_rdy++;
            if (bus.resp_valid === 1'b1) begin
                n_resp++;
                vectors++;
                if ({bus.resp_data, bus.resp_rd} !== {32'hCAFE_F00D, 5'd3}) begin
                    miscompares++;
                    $display("FAIL b2b.resp: got data=%h rd=%h required cafef00d 03", bus.resp_data, bus.resp_rd);
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        vectors++;
        if (n_rdy !== 10) begin
            miscompares++;
            $display("FAIL b2b.accept_count: got %0d required 10", n_rdy);
        end
        vectors++;
        if (n_resp !== 10) begin
            miscompares++;
            $display("FAIL b2b.resp_count: got %0d required 10", n_resp);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic        st;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [4:0]  r;
        int          ready_at;
        for (int n = 0; n < 60; n++) begin
            f3       = 3'($urandom_range(0, 7));
            st       = 1'($urandom);
            a        = $urandom;
            wd       = $urandom;
            rdata    = $urandom;
            r        = 5'($urandom);
            ready_at = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
            run_op(f3, st, a, wd, r, rdata, ready_at,
                   m_fault(int'(f3), st, longint'(a)),
                   m_strb(int'(f3), st, longint'(a)),
                   m_wdata(int'(f3), longint'(wd)),
                   st ? 32'h0 : m_load(int'(f3), longint'(a), longint'(rdata)),
                   "random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
